smi_byte_data_realign: RTL and testbench

Read-path counterpart to the SMI write-side byte aligner. Accepts AXI read data beats whose payload starts at an arbitrary byte lane (the low bits of the read address) and repacks them into SMI flits that start at byte 0, with the end-of-frame control (eofc) set on the final flit. It sits between the AXI read data channel and the SMI response flit output of the memory access engine.

---
 rtl/smi_byte_data_realign.sv | 206 ++++++++++++++++++++
 tb/tb_smi_byte_data_realign.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_byte_data_realign.sv
// smi_byte_data_realign
// Repacks AXI read beats whose payload starts at an arbitrary byte lane into
// SMI flits that start at byte 0. The final flit carries the valid byte count
// in smiOutEofc, and unused upper bytes are forced to zero.
//
// Pipeline: beats are taken at the port and combined with the previously held
// beat. The shifted and masked flit is registered in stage 1. It is then
// copied into the output register that drives smiOut*. A registered output
// with smiOutStop high freezes the whole datapath.
module smi_byte_data_realign #(
  parameter int FlitWidth = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   setupReady,
  input  logic [7:0]             byteOffset,
  input  logic [15:0]            byteCount,
  output logic                   setupStop,
  input  logic                   axiInReady,
  input  logic [FlitWidth*8-1:0] axiInData,
  input  logic                   axiInLast,
  output logic                   axiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  output logic                   alignError
);

  localparam int OFF_W = $clog2(FlitWidth);
  localparam int DW    = FlitWidth * 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_STREAM,
    S_TAIL
  } state_t;

  state_t state, state_nxt;

  // Per-frame values, latched when the setup is accepted.
  logic [OFF_W-1:0] off_q;
  logic [16:0]      nbeats_q;
  logic [16:0]      nflits_q;
  logic [7:0]       eofc_q;
  logic [16:0]      beat_cnt_q;
  logic [DW-1:0]    held_q;

  // Stage 1 holds the computed flit. The output register drives the port.
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic [7:0]    s1_eofc;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    out_eofc;

  // Setup-time derivations.
  logic [OFF_W-1:0] off_in;
  logic [16:0]      span_in;
  logic [16:0]      nbeats_in;
  logic [16:0]      nflits_in;
  logic [OFF_W-1:0] last_lane_in;
  logic [7:0]       eofc_in;

  logic            stall;
  logic            setup_fire;
  logic            beat_fire;
  logic            last_beat;
  logic            flits_short;
  logic            is_final;
  logic            emit;
  logic [DW-1:0]   upper;
  logic [2*DW-1:0] wide;
  logic [DW-1:0]   flit;
  logic            unused_bits;

  assign off_in       = byteOffset[OFF_W-1:0];
  assign span_in      = 17'(off_in) + 17'(byteCount);
  assign nbeats_in    = (span_in + 17'(FlitWidth - 1)) >> OFF_W;
  assign nflits_in    = (17'(byteCount) + 17'(FlitWidth - 1)) >> OFF_W;
  assign last_lane_in = OFF_W'(byteCount[OFF_W-1:0] - 1'b1);
  assign eofc_in      = 8'(last_lane_in) + 8'd1;

  // A full output register that the sink refuses stalls every stage.
  assign stall      = out_valid & smiOutStop;
  assign setupStop  = srst | (state != S_IDLE);
  assign axiInStop  = srst | ~((state == S_FIRST) | (state == S_STREAM)) | stall;
  assign setup_fire = setupReady & ~setupStop;
  assign beat_fire  = axiInReady & ~axiInStop;

  assign last_beat   = (beat_cnt_q == nbeats_q - 17'd1);
  assign flits_short = (nflits_q == nbeats_q - 17'd1);

  // A flit is final either in Tail or on the last beat when no Tail is needed.
  assign is_final = (state == S_TAIL) |
                    ((state == S_STREAM) & last_beat & flits_short);
  assign emit     = ((state == S_STREAM) & beat_fire) |
                    ((state == S_TAIL) & ~stall);

  // Build the outgoing flit from {new beat, held beat}, shifted down by the lane offset.
  // NOTE: always_comb assigns every output before any condition, so no latch can be inferred.
  always_comb begin
    upper = (state == S_TAIL) ? '0 : axiInData;
    wide  = {upper, held_q} >> {off_q, 3'b000};
    flit  = '0;
    for (int i = 0; i < FlitWidth; i++) begin
      if (!is_final || (i < int'(eofc_q))) begin
        flit[i*8 +: 8] = wide[i*8 +: 8];
      end
    end
  end

  assign unused_bits = ^{byteOffset[7:OFF_W], wide[2*DW-1:DW]};

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (setup_fire && (byteCount != 16'd0)) begin
          state_nxt = S_FIRST;
        end
      end
      S_FIRST: begin
        if (beat_fire) begin
          state_nxt = (nbeats_q == 17'd1) ? S_TAIL : S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_fire && last_beat) begin
          state_nxt = flits_short ? S_IDLE : S_TAIL;
        end
      end
      S_TAIL: begin
        if (!stall) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, beat counter and the sticky RLAST mismatch flag.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= S_IDLE;
      beat_cnt_q <= '0;
      alignError <= 1'b0;
    end else begin
      state <= state_nxt;
      if (setup_fire) begin
        beat_cnt_q <= '0;
      end else if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + 17'd1;
        if (axiInLast != last_beat) begin
          alignError <= 1'b1;
        end
      end
    end
  end

  // Frame parameters and the held beat.
  // NOTE: datapath registers are not reset; valid flags and state qualify them.
  always_ff @(posedge clk) begin
    if (setup_fire) begin
      off_q    <= off_in;
      nbeats_q <= nbeats_in;
      nflits_q <= nflits_in;
      eofc_q   <= eofc_in;
    end
    if (beat_fire) begin
      held_q <= axiInData;
    end
  end

  // Stage 1 and the output register advance together whenever not stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_eofc  <= 8'd0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      out_eofc  <= s1_valid ? s1_eofc : 8'd0;
      s1_valid  <= emit;
    end
  end

  // Payload halves of the pipeline, loaded under the same advance condition.
  always_ff @(posedge clk) begin
    if (!stall) begin
      out_data <= s1_data;
      if (emit) begin
        s1_data <= flit;
        s1_eofc <= is_final ? eofc_q : 8'd0;
      end
    end
  end

  assign smiOutReady = out_valid;
  assign smiOutData  = out_data;
  assign smiOutEofc  = out_eofc;

endmodule

// File: tb/tb_smi_byte_data_realign.sv
// Directed bench for smi_byte_data_realign (FlitWidth = 16).
// Output flits are collected into a queue, and each frame's flits are compared
// against hand-computed values or a byte-level address model.
module tb_smi_byte_data_realign;

  logic         clk = 1'b0;
  logic         srst;
  logic         setupReady;
  logic [7:0]   byteOffset;
  logic [15:0]  byteCount;
  logic         setupStop;
  logic         axiInReady;
  logic [127:0] axiInData;
  logic         axiInLast;
  logic         axiInStop;
  logic         smiOutReady;
  logic [7:0]   smiOutEofc;
  logic [127:0] smiOutData;
  logic         smiOutStop;
  logic         alignError;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   eofc;
  } flit_t;

  flit_t        q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic         stop_rand = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [7:0]   prev_eofc;

  smi_byte_data_realign #(.FlitWidth(16)) dut (
    .clk        (clk),
    .srst       (srst),
    .setupReady (setupReady),
    .byteOffset (byteOffset),
    .byteCount  (byteCount),
    .setupStop  (setupStop),
    .axiInReady (axiInReady),
    .axiInData  (axiInData),
    .axiInLast  (axiInLast),
    .axiInStop  (axiInStop),
    .smiOutReady(smiOutReady),
    .smiOutEofc (smiOutEofc),
    .smiOutData (smiOutData),
    .smiOutStop (smiOutStop),
    .alignError (alignError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sink side: capture transfers and verify hold-while-stopped.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_hold_ready", 128'(smiOutReady), 128'd1);
      check("stall_hold_data", smiOutData, prev_data);
      check("stall_hold_eofc", 128'(smiOutEofc), 128'(prev_eofc));
    end
    prev_stall = smiOutReady && smiOutStop && !srst;
    prev_data  = smiOutData;
    prev_eofc  = smiOutEofc;
    if (smiOutReady && !smiOutStop && !srst) begin
      q.push_back('{data: smiOutData, eofc: smiOutEofc});
    end
  end

  // Output backpressure generator.
  initial begin
    smiOutStop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      smiOutStop = stop_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  function automatic logic [127:0] mk_beat(input logic [7:0] base);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  // Byte-level model: flit k byte i is payload byte 16k+i at address off+16k+i.
  // Beat j of the stream holds byte values 8'h10*(j+1) + lane.
  function automatic logic [127:0] model_flit(input int k, input int off, input int cnt);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      if (k * 16 + i < cnt) begin
        int g;
        g = off + k * 16 + i;
        d[i*8 +: 8] = 8'(16 * (g / 16 + 1) + g % 16);
      end
    end
    return d;
  endfunction

  // Tasks start and finish just after a rising edge.
  task automatic do_setup(input logic [7:0] off, input logic [15:0] cnt);
    int n;
    n = 0;
    setupReady = 1'b1;
    byteOffset = off;
    byteCount  = cnt;
    do begin
      @(negedge clk);
      n++;
    end while (setupStop && n < 200);
    check("setup_accept", 128'(!setupStop), 128'd1);
    @(posedge clk);
    #1;
    setupReady = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last);
    int n;
    n = 0;
    axiInReady = 1'b1;
    axiInData  = d;
    axiInLast  = last;
    do begin
      @(negedge clk);
      n++;
    end while (axiInStop && n < 200);
    check("beat_accept", 128'(!axiInStop), 128'd1);
    @(posedge clk);
    #1;
    axiInReady = 1'b0;
    axiInData  = '0;
    axiInLast  = 1'b0;
  endtask

  // Wait for n flits within a cycle budget, then a few more cycles so duplicates show up.
  task automatic wait_flits(input string tag, input int n);
    int c;
    c = 0;
    while (q.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    check(tag, 128'(q.size()), 128'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_flit(input string tag, input int idx, input logic [127:0] d, input logic [7:0] e);
    if (idx < q.size()) begin
      check({tag, "_data"}, q[idx].data, d);
      check({tag, "_eofc"}, 128'(q[idx].eofc), 128'(e));
    end else begin
      check({tag, "_missing"}, 128'(q.size()), 128'(idx + 1));
    end
  endtask

  initial begin
    srst       = 1'b1;
    setupReady = 1'b0;
    byteOffset = '0;
    byteCount  = '0;
    axiInReady = 1'b0;
    axiInData  = '0;
    axiInLast  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_setupStop", 128'(setupStop), 128'd1);
    check("rst_axiInStop", 128'(axiInStop), 128'd1);
    check("rst_smiOutReady", 128'(smiOutReady), 128'd0);
    check("rst_smiOutEofc", 128'(smiOutEofc), 128'd0);
    check("rst_alignError", 128'(alignError), 128'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    check("idle_setupStop", 128'(setupStop), 128'd0);
    @(posedge clk);
    #1;

    // off=0, count=32: two aligned flits, the second via Tail.
    do_setup(8'd0, 16'd32);
    send_beat(mk_beat(8'hA0), 1'b0);
    send_beat(mk_beat(8'hB0), 1'b1);
    wait_flits("t1_count", 2);
    check_flit("t1_f0", 0, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 8'd0);
    check_flit("t1_f1", 1, 128'hBFBEBDBC_BBBAB9B8_B7B6B5B4_B3B2B1B0, 8'd16);
    check("t1_alignError", 128'(alignError), 128'd0);
    q.delete();

    // off=3, count=20: stream flit plus a masked Tail flit.
    do_setup(8'd3, 16'd20);
    send_beat(mk_beat(8'hA0), 1'b0);
    send_beat(mk_beat(8'hB0), 1'b1);
    wait_flits("t2_count", 2);
    check_flit("t2_f0", 0, 128'hB2B1B0AF_AEADACAB_AAA9A8A7_A6A5A4A3, 8'd0);
    check_flit("t2_f1", 1, 128'h00000000_00000000_00000000_B6B5B4B3, 8'd4);
    q.delete();

    // off=12, count=8: a single flit spanning two beats, no Tail.
    do_setup(8'd12, 16'd8);
    send_beat(mk_beat(8'hA0), 1'b0);
    send_beat(mk_beat(8'hB0), 1'b1);
    wait_flits("t3_count", 1);
    check_flit("t3_f0", 0, 128'h00000000_00000000_B3B2B1B0_AFAEADAC, 8'd8);
    q.delete();

    // off=5, count=64 under random output backpressure.
    stop_rand = 1'b1;
    do_setup(8'd5, 16'd64);
    for (int j = 0; j < 5; j++) send_beat(mk_beat(8'(16 * (j + 1))), j == 4);
    wait_flits("t4_count", 4);
    stop_rand = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_flit($sformatf("t4_f%0d", k), k, model_flit(k, 5, 64), (k == 3) ? 8'd16 : 8'd0);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1;

    // RLAST on beat 0 of a two-beat frame.
    do_setup(8'd0, 16'd20);
    send_beat(mk_beat(8'hA0), 1'b1);
    send_beat(mk_beat(8'hB0), 1'b1);
    wait_flits("t5_count", 2);
    check_flit("t5_f0", 0, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 8'd0);
    check_flit("t5_f1", 1, 128'h00000000_00000000_00000000_B3B2B1B0, 8'd4);
    check("t5_alignError_set", 128'(alignError), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    check("t5_alignError_sticky", 128'(alignError), 128'd1);
    q.delete();
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    check("t5_alignError_clr", 128'(alignError), 128'd0);
    @(posedge clk);
    #1;

    // srst in the middle of a 4-beat frame, then a fresh 16-byte frame.
    do_setup(8'd0, 16'd64);
    send_beat(mk_beat(8'h60), 1'b0);
    send_beat(mk_beat(8'h70), 1'b0);
    send_beat(mk_beat(8'h80), 1'b0);
    srst = 1'b1;
    @(negedge clk);
    check("t6_rst_setupStop", 128'(setupStop), 128'd1);
    @(posedge clk);
    #1;
    srst = 1'b0;
    q.delete();
    do_setup(8'd0, 16'd16);
    send_beat(mk_beat(8'hC0), 1'b1);
    wait_flits("t6_count", 1);
    check_flit("t6_f0", 0, 128'hCFCECDCC_CBCAC9C8_C7C6C5C4_C3C2C1C0, 8'd16);
    check("t6_alignError", 128'(alignError), 128'd0);
    q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
